// File: rtl/stream_arb2_pkg.sv
// Shared types and codes for the two-input stream arbiter.
package stream_arb2_pkg;

    // Arbiter grant state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    // Output source codes.
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Sideband carried alongside each data word through the output stage.
    typedef struct packed {
        logic last;
        logic src;
    } word_tag_t;

    // Grant state for a tie, given the port that was served last.
    function automatic state_e tie_grant(input logic rr_last);
        return (rr_last == SRC_A) ? GNT_B : GNT_A;
    endfunction

endpackage

// File: rtl/stream_arb2_if.sv
// Valid/ready stream bundle: en/last/data flow master->slave, rdy flows back.
interface stream_arb2_if #(
    parameter int unsigned DW = 8
) ();
    logic          rdy;
    logic          en;
    logic          last;
    logic [DW-1:0] data;

    modport master (input rdy, output en, output last, output data);
    modport slave  (output rdy, input en, input last, input data);
endinterface

// File: rtl/stream_oreg.sv
// Single-entry registered output stage with en/rdy handshake.
module stream_oreg #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    input  logic         out_rdy,
    output logic         out_en,
    output logic [W-1:0] out_data
);
    logic         en_q, en_d;
    logic [W-1:0] data_q, data_d;

    // Load on upstream transfer, drop valid on handoff, otherwise hold.
    always_comb begin
        en_d   = en_q;
        data_d = data_q;
        if (in_vld) begin
            en_d   = 1'b1;
            data_d = in_data;
        end else if (out_rdy) begin
            en_d   = 1'b0;
        end
    end

    // Output word register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q   <= 1'b0;
            data_q <= '0;
        end else begin
            en_q   <= en_d;
            data_q <= data_d;
        end
    end

    assign out_en   = en_q;
    assign out_data = data_q;
endmodule

// File: rtl/stream_arb2.sv
// Two-port round-robin packet arbiter with burst limit and registered output.
module stream_arb2
    import stream_arb2_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned MAXBURST = 16
) (
    input  logic          clk,
    input  logic          rstn,
    stream_arb2_if.slave  a,
    stream_arb2_if.slave  b,
    stream_arb2_if.master o,
    output logic          o_src
);
    localparam int unsigned CW = $clog2(MAXBURST + 1);
    localparam int unsigned OW = DW + 2;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic           rr_q, rr_d;
    logic           burst_done;
    logic           room;
    logic           a_rdy_c, b_rdy_c;
    logic           a_xfer, b_xfer;
    logic           oreg_en;
    word_tag_t      in_tag;
    logic [OW-1:0]  in_word;
    logic [OW-1:0]  out_word;

    // Output stage can take a word when empty or emptying this cycle.
    assign room    = ~oreg_en | o.rdy;
    assign a_rdy_c = (state_q == GNT_A) & room;
    assign b_rdy_c = (state_q == GNT_B) & room;
    assign a_xfer  = a.en & a_rdy_c;
    assign b_xfer  = b.en & b_rdy_c;
    assign a.rdy   = a_rdy_c;
    assign b.rdy   = b_rdy_c;

    assign cnt_inc    = cnt_q + CW'(1);
    assign burst_done = (cnt_inc == CW'(MAXBURST));

    // Grant FSM: pick a port from IDLE, hold until last word or burst limit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (a.en && b.en) begin
                    state_d = tie_grant(rr_q);
                end else if (a.en) begin
                    state_d = GNT_A;
                end else if (b.en) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                if (a_xfer) begin
                    cnt_d = cnt_inc;
                    if (a.last || burst_done) begin
                        state_d = IDLE;
                        rr_d    = SRC_A;
                    end
                end
            end
            GNT_B: begin
                if (b_xfer) begin
                    cnt_d = cnt_inc;
                    if (b.last || burst_done) begin
                        state_d = IDLE;
                        rr_d    = SRC_B;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Grant state, burst counter and round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= SRC_B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // Select the transferring port's word and tag it with its source.
    always_comb begin
        in_tag.last = b_xfer ? b.last : a.last;
        in_tag.src  = b_xfer ? SRC_B : SRC_A;
        in_word     = {in_tag, (b_xfer ? b.data : a.data)};
    end

    stream_oreg #(
        .W (OW)
    ) u_oreg (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (a_xfer | b_xfer),
        .in_data  (in_word),
        .out_rdy  (o.rdy),
        .out_en   (oreg_en),
        .out_data (out_word)
    );

    assign o.en                      = oreg_en;
    assign {o.last, o_src, o.data}   = out_word;
endmodule

// File: tb/tb_stream_arb2.sv
// Randomized self-checking bench for stream_arb2 against a packet-level model.
module tb_stream_arb2;
    import stream_arb2_pkg::*;

    localparam int unsigned MB = 4;

    logic clk = 1'b0;
    logic rstn;
    logic o_src;

    always #5 clk = ~clk;

    stream_arb2_if #(.DW(8)) a_if ();
    stream_arb2_if #(.DW(8)) b_if ();
    stream_arb2_if #(.DW(8)) o_if ();

    stream_arb2 #(
        .DW       (8),
        .MAXBURST (MB)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .a     (a_if),
        .b     (b_if),
        .o     (o_if),
        .o_src (o_src)
    );

    logic [8:0] a_q[$];
    logic [8:0] b_q[$];
    logic [9:0] exp_q[$];
    bit         exp_bs[$];
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    int         n_err = 0;
    int         n_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_pkt(input bit port_b, input int len);
        logic [8:0] w;
        for (int i = 0; i < len; i++) begin
            w = {(i == len - 1), 8'($urandom)};
            if (port_b) b_q.push_back(w);
            else        a_q.push_back(w);
        end
    endtask

    // Packet-level model: alternate on contention, bursts cut at last or MB words.
    task automatic build_expected();
        logic [8:0] qa[$];
        logic [8:0] qb[$];
        logic [8:0] w;
        bit         turn_a;
        bit         serve_a;
        int         n;
        qa = a_q;
        qb = b_q;
        exp_a = a_q;
        exp_b = b_q;
        exp_q.delete();
        exp_bs.delete();
        turn_a = 1'b1;
        while (qa.size() > 0 || qb.size() > 0) begin
            serve_a = (qa.size() > 0 && qb.size() > 0) ? turn_a : (qa.size() > 0);
            n = 0;
            do begin
                w = serve_a ? qa.pop_front() : qb.pop_front();
                exp_q.push_back({~serve_a, w});
                exp_bs.push_back(n == 0);
                n++;
            end while (!w[8] && n < int'(MB));
            turn_a = ~serve_a;
        end
    endtask

    task automatic drive(input bit ax, input bit bx, input int gap, input int stall,
                         input int stall_at, input int cyc);
        if (!(a_if.en && !ax)) begin
            if (a_q.size() > 0 && $urandom_range(99) >= gap) begin
                a_if.en = 1'b1;
                {a_if.last, a_if.data} = a_q[0];
            end else begin
                a_if.en = 1'b0;
            end
        end
        if (!(b_if.en && !bx)) begin
            if (b_q.size() > 0 && $urandom_range(99) >= gap) begin
                b_if.en = 1'b1;
                {b_if.last, b_if.data} = b_q[0];
            end else begin
                b_if.en = 1'b0;
            end
        end
        if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) o_if.rdy = 1'b0;
        else o_if.rdy = ($urandom_range(99) >= stall);
    endtask

    task automatic run_scn(input int gap, input int stall, input int stall_at,
                           input bit full_order, input int first_en_exp);
        int         cyc = 0;
        int         remaining;
        int         last_ho = -1;
        int         first_en = -1;
        bit         ax = 0, bx = 0, ox = 0, prev_stall = 0, bs, chk_t;
        logic [9:0] ow, prev_word, ew;
        logic [8:0] sw;
        build_expected();
        remaining = a_q.size() + b_q.size();
        chk_t = full_order && stall == 0 && stall_at < 0;
        for (;;) begin
            drive(ax, bx, gap, stall, stall_at, cyc);
            #1;
            ax = a_if.en & a_if.rdy;
            bx = b_if.en & b_if.rdy;
            ox = o_if.en & o_if.rdy;
            ow = {o_src, o_if.last, o_if.data};
            prev_stall = o_if.en & ~o_if.rdy;
            prev_word = ow;
            check("rdy_exclusive", 32'(a_if.rdy & b_if.rdy), 0);
            if (prev_stall) check("rdy_blocked", 32'(a_if.rdy | b_if.rdy), 0);
            if (remaining == 0 || cyc >= 1500) break;
            @(negedge clk);
            cyc++;
            if (first_en < 0 && o_if.en) first_en = cyc;
            if (prev_stall) begin
                check("stall_hold_en", 32'(o_if.en), 1);
                check("stall_hold_word", 32'({o_src, o_if.last, o_if.data}), 32'(prev_word));
            end
            if (ax) void'(a_q.pop_front());
            if (bx) void'(b_q.pop_front());
            if (ox) begin
                remaining--;
                if (full_order) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 32'(ow), 32'h3ff);
                    end else begin
                        ew = exp_q.pop_front();
                        bs = exp_bs.pop_front();
                        check("order_word", 32'(ow), 32'(ew));
                        if (chk_t && last_ho >= 0) check("handoff_gap", 32'(cyc - last_ho), bs ? 2 : 1);
                        last_ho = cyc;
                    end
                end else begin
                    if ((ow[9] ? exp_b.size() : exp_a.size()) == 0) begin
                        check("extra_word", 32'(ow), 32'h3ff);
                    end else begin
                        sw = ow[9] ? exp_b.pop_front() : exp_a.pop_front();
                        check("src_word", 32'(ow[8:0]), 32'(sw));
                    end
                end
            end
        end
        check("scn_timeout", 32'(remaining), 0);
        if (first_en_exp >= 0) check("first_en_cycle", 32'(first_en), 32'(first_en_exp));
        a_if.en = 1'b0;
        b_if.en = 1'b0;
        o_if.rdy = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        a_if.en = 1'b0; a_if.last = 1'b0; a_if.data = '0;
        b_if.en = 1'b0; b_if.last = 1'b0; b_if.data = '0;
        o_if.rdy = 1'b1;
        a_q.delete();
        b_q.delete();
        repeat (2) @(negedge clk);
        check("rst_o_en", 32'(o_if.en), 0);
        check("rst_o_word", 32'({o_src, o_if.last, o_if.data}), 0);
        check("rst_rdy", 32'({a_if.rdy, b_if.rdy}), 0);
        rstn = 1'b1;
    endtask

    initial begin
        int t;
        // Single 3-word packet: latency and ordering.
        do_reset();
        add_pkt(0, 3);
        run_scn(0, 0, -1, 1, 2);

        // Contention with 2-word packets: A,A,B,B,A,A with bubbles.
        do_reset();
        add_pkt(0, 2); add_pkt(0, 2); add_pkt(1, 2);
        run_scn(0, 0, -1, 1, -1);

        // Long packet, other port idle: forced splits 4,4,2.
        do_reset();
        add_pkt(0, 10);
        run_scn(0, 0, -1, 1, -1);

        // Long packet interleaved with single-word packets.
        do_reset();
        add_pkt(0, 10); add_pkt(1, 1); add_pkt(1, 1);
        run_scn(0, 0, -1, 1, -1);

        // Five-cycle downstream stall mid-burst.
        do_reset();
        add_pkt(0, 8);
        run_scn(0, 0, 3, 1, -1);

        // Continuous sources, random backpressure: exact order still predictable.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int p = 0; p < 4; p++) begin
                add_pkt(0, $urandom_range(1, 9));
                add_pkt(1, $urandom_range(1, 9));
            end
            run_scn(0, 40, -1, 1, -1);
        end

        // Bursty sources and backpressure: per-source order, no loss or duplication.
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < 4; p++) begin
                if ($urandom_range(1)) add_pkt(0, $urandom_range(1, 9));
                if ($urandom_range(1)) add_pkt(1, $urandom_range(1, 9));
            end
            run_scn(30, 30, -1, 0, -1);
        end

        // Reset mid-burst: held word dropped, round-robin pointer back to B.
        do_reset();
        add_pkt(0, 1);
        run_scn(0, 0, -1, 1, -1);
        b_if.en = 1'b1; b_if.last = 1'b0; b_if.data = 8'h5a;
        o_if.rdy = 1'b0;
        t = 0;
        while (!o_if.en && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("mid_en_seen", 32'(o_if.en), 1);
        check("mid_src_b", 32'(o_src), 32'(SRC_B));
        #2 rstn = 1'b0;
        #1;
        check("async_rst_en", 32'(o_if.en), 0);
        check("async_rst_word", 32'({o_src, o_if.last, o_if.data}), 0);
        check("async_rst_rdy", 32'({a_if.rdy, b_if.rdy}), 0);
        @(negedge clk);
        a_if.en = 1'b1; a_if.last = 1'b1; a_if.data = 8'hc3;
        b_if.last = 1'b1;
        o_if.rdy = 1'b1;
        rstn = 1'b1;
        t = 0;
        while (!o_if.en && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("post_rst_seen", 32'(o_if.en), 1);
        check("post_rst_tie_a", 32'({o_src, o_if.data}), 32'({SRC_A, 8'hc3}));
        a_if.en = 1'b0;
        b_if.en = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
